dmem_arbiter: RTL and testbench
===============================

Name: dmem_arbiter

Overview:
- Shares the single-port data RAM between two requesters: the CPU MEM stage and an external debug/loader port (testbench preload, memory inspection).
- Sits between the MEM stage, the debug master and the `ram` instance.
- Decides every cycle which requester drives the RAM and raises a stall to the CPU when it loses.
- Bounded-fairness rule: the debug port cannot be starved by a long CPU load/store run.

Parameters:
- AW, 32, address width of both requesters and the RAM.
- DW, 32, data width.
- MAX_CPU_RUN, 4, consecutive CPU grants allowed while a debug request is pending (range 1..15).
- CNT_W, 16, width of the stall statistics counter.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- cpu_req  in  1  MEM stage wants the RAM (LW or SW in MEM).
- cpu_we  in  1  1 = store, 0 = load.
- cpu_addr  in  AW  byte address from MEM stage.
- cpu_wdata  in  DW  store data.
- cpu_rdata  out  DW  load data to MEM stage.
- cpu_stall  out  1  CPU request not served this cycle; pipeline must hold.
- dbg_req  in  1  debug request; held high until dbg_ack.
- dbg_we  in  1  1 = write, 0 = read.
- dbg_addr  in  AW  debug address.
- dbg_wdata  in  DW  debug write data.
- dbg_ack  out  1  one-cycle pulse, request completed.
- dbg_rdata  out  DW  read data, valid while dbg_ack = 1.
- ram_we  out  1  RAM write enable.
- ram_re  out  1  RAM read enable.
- ram_addr  out  AW  RAM address.
- ram_wdata  out  DW  RAM write data.
- ram_rdata  in  DW  RAM read data, combinational from ram_addr/ram_re.
- stall_cnt  out  CNT_W  saturating count of cycles with cpu_stall = 1.

Behaviour:
Reset:
- Asynchronous, active-high.
- State = IDLE, run counter = 0, dbg_ack = 0, dbg_rdata = 0, stall_cnt = 0.
- All RAM strobes are 0.

States:
- IDLE: no debug acknowledgement outstanding.
- DACK: debug was granted last cycle; dbg_ack = 1 in this state.

Grant decision (combinational, per cycle):
- dbg_ok = dbg_req & (state == IDLE).
- gnt_dbg = dbg_ok & (~cpu_req | run == MAX_CPU_RUN).
- gnt_cpu = cpu_req & ~gnt_dbg.

Muxing:
- The granted requester's we/addr/wdata drive the RAM.
- ram_re = granted & ~we.
- With no grant, all RAM strobes are 0; address and data are don't-care but held at 0.

CPU side (zero-latency):
- cpu_rdata = ram_rdata while gnt_cpu, else 0.
- cpu_stall = cpu_req & ~gnt_cpu.

Debug side (one-cycle latency):
- On gnt_dbg: next state = DACK, and dbg_rdata <= ram_rdata (reads only; writes leave dbg_rdata unchanged).
- DACK always returns to IDLE next cycle.
- The master drops or refreshes dbg_req in the DACK cycle. A request still high in DACK is treated as a new request from the following cycle.
- Back-to-back debug accesses therefore take 2 cycles each.

Run counter (4 bits):
- Cleared when gnt_dbg or when dbg_req = 0.
- Incremented on gnt_cpu while dbg_ok, saturating at MAX_CPU_RUN.
- Otherwise held.

stall_cnt:
- +1 on each cycle with cpu_stall = 1.
- Saturates at all-ones; never wraps.

Boundary conditions:
- Simultaneous requests with run < MAX_CPU_RUN: CPU wins.
- CPU stalled by a debug grant: served the next cycle, because the debug side is in DACK and ineligible. Worst-case CPU stall is therefore 1 cycle.
- Debug worst-case latency: MAX_CPU_RUN + 1 cycles from request to grant.
- Both requests targeting the same address in consecutive cycles: no forwarding. Ordering follows the grant order.
- Reset asserted mid-DACK: dbg_ack drops immediately (asynchronous). The debug access is considered lost; the master must retry.
- cpu_req low: cpu_stall = 0 regardless of debug activity.

Test Plan:
1. Reset release, then CPU LW with cpu_addr = 0x10 and RAM[0x10] = 0xDEADBEEF, dbg_req = 0 -> same cycle: ram_re = 1, cpu_rdata = 0xDEADBEEF, cpu_stall = 0; stall_cnt stays 0.
2. Debug write: dbg_we = 1, addr 0x20, data 0x12345678, no CPU traffic -> ram_we = 1 in the grant cycle, dbg_ack = 1 the next cycle. A following CPU LW of 0x20 returns 0x12345678.
3. Starvation: cpu_req held high for 10 cycles, dbg_req (read 0x20) raised in cycle 0, MAX_CPU_RUN = 4 -> CPU granted in cycles 0–3; debug granted in cycle 4 with cpu_stall = 1; dbg_ack = 1 with dbg_rdata = 0x12345678 in cycle 5; CPU granted again in cycle 5; stall_cnt = 1.
4. Debug alone, dbg_req held high for 6 cycles -> grants in cycles 0, 2, 4 and dbg_ack in cycles 1, 3, 5; run counter stays 0.
5. Assert reset in the DACK cycle of a debug read -> dbg_ack = 0 and dbg_rdata = 0 immediately; state = IDLE after release.
6. Force stall_cnt near saturation (CNT_W = 4 build) with 20 stall cycles -> stall_cnt holds at 0xF.

Source files
------------

// File: rtl/dmem_arbiter.sv
`default_nettype none
// dmem_arbiter: shares the single-port data RAM between the CPU MEM stage and a debug/loader port.
// The CPU wins by default; a pending debug request is forced through after MAX_CPU_RUN CPU grants.
module dmem_arbiter #(
  parameter int AW          = 32,
  parameter int DW          = 32,
  parameter int MAX_CPU_RUN = 4,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cpu_req,
  input  logic             cpu_we,
  input  logic [AW-1:0]    cpu_addr,
  input  logic [DW-1:0]    cpu_wdata,
  output logic [DW-1:0]    cpu_rdata,
  output logic             cpu_stall,
  input  logic             dbg_req,
  input  logic             dbg_we,
  input  logic [AW-1:0]    dbg_addr,
  input  logic [DW-1:0]    dbg_wdata,
  output logic             dbg_ack,
  output logic [DW-1:0]    dbg_rdata,
  output logic             ram_we,
  output logic             ram_re,
  output logic [AW-1:0]    ram_addr,
  output logic [DW-1:0]    ram_wdata,
  input  logic [DW-1:0]    ram_rdata,
  output logic [CNT_W-1:0] stall_cnt
);

  typedef enum logic {
    IDLE = 1'b0,
    DACK = 1'b1
  } state_t;

  localparam logic [3:0] RUN_LIMIT = 4'(MAX_CPU_RUN);

  state_t     state;
  state_t     state_next;
  logic [3:0] run;
  logic       dbg_ok;
  logic       gnt_dbg;
  logic       gnt_cpu;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Grant decision and FSM next state; DACK always falls back to IDLE.
  always_comb begin
    dbg_ok     = dbg_req && (state == IDLE);
    gnt_dbg    = dbg_ok && (!cpu_req || (run == RUN_LIMIT));
    gnt_cpu    = cpu_req && !gnt_dbg;
    state_next = IDLE;
    if (gnt_dbg) begin
      state_next = DACK;
    end
    cpu_stall  = cpu_req && !gnt_cpu;
    dbg_ack    = (state == DACK);
  end

  always_comb begin
    ram_we    = 1'b0;
    ram_re    = 1'b0;
    ram_addr  = '0;
    ram_wdata = '0;
    if (gnt_cpu) begin
      ram_we    = cpu_we;
      ram_re    = !cpu_we;
      ram_addr  = cpu_addr;
      ram_wdata = cpu_wdata;
    end else if (gnt_dbg) begin
      ram_we    = dbg_we;
      ram_re    = !dbg_we;
      ram_addr  = dbg_addr;
      ram_wdata = dbg_wdata;
    end
  end

  assign cpu_rdata = gnt_cpu ? ram_rdata : '0;

  // Run counter only advances while a debug request is actually eligible and losing.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      run <= '0;
    end else if (gnt_dbg || !dbg_req) begin
      run <= '0;
    end else if (gnt_cpu && dbg_ok && (run != RUN_LIMIT)) begin
      run <= run + 4'd1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      dbg_rdata <= '0;
    end else if (gnt_dbg && !dbg_we) begin
      dbg_rdata <= ram_rdata;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_cnt <= '0;
    end else if (cpu_stall && (stall_cnt != {CNT_W{1'b1}})) begin
      stall_cnt <= stall_cnt + CNT_W'(1);
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_dmem_arbiter.sv
`default_nettype none
// tb_dmem_arbiter: randomized + directed scoreboard bench for dmem_arbiter against a behavioural model.
module tb_dmem_arbiter;

  localparam int MAXRUN = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        preload = 1'b1;
  logic        mon_en = 1'b0;
  logic        cpu_req = 1'b0, cpu_we = 1'b0;
  logic [31:0] cpu_addr = '0, cpu_wdata = '0;
  logic        dbg_req = 1'b0, dbg_we = 1'b0;
  logic [31:0] dbg_addr = '0, dbg_wdata = '0;
  logic [31:0] cpu_rdata, dbg_rdata, ram_addr, ram_wdata, ram_rdata;
  logic        cpu_stall, dbg_ack, ram_we, ram_re;
  logic [15:0] stall_cnt;
  logic [31:0] sm_cpu_rdata, sm_dbg_rdata, sm_ram_addr, sm_ram_wdata;
  logic        sm_cpu_stall, sm_dbg_ack, sm_ram_we, sm_ram_re;
  logic [3:0]  sm_stall_cnt;

  always #5 clk = ~clk;

  dmem_arbiter #(.AW(32), .DW(32), .MAX_CPU_RUN(MAXRUN), .CNT_W(16)) dut (
    .clk(clk), .reset(reset),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
    .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
    .dbg_ack(dbg_ack), .dbg_rdata(dbg_rdata),
    .ram_we(ram_we), .ram_re(ram_re), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
    .ram_rdata(ram_rdata), .stall_cnt(stall_cnt)
  );

  // Narrow-counter build driven in lockstep to exercise saturation.
  dmem_arbiter #(.AW(32), .DW(32), .MAX_CPU_RUN(MAXRUN), .CNT_W(4)) u_small (
    .clk(clk), .reset(reset),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(sm_cpu_rdata), .cpu_stall(sm_cpu_stall),
    .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
    .dbg_ack(sm_dbg_ack), .dbg_rdata(sm_dbg_rdata),
    .ram_we(sm_ram_we), .ram_re(sm_ram_re), .ram_addr(sm_ram_addr), .ram_wdata(sm_ram_wdata),
    .ram_rdata(ram_rdata), .stall_cnt(sm_stall_cnt)
  );

  function automatic logic [31:0] init_word(input int i);
    return (i == 4) ? 32'hDEADBEEF : 32'h1000_0000 + 32'(i) * 32'h0101_0101;
  endfunction

  logic [31:0] ram [0:63];
  assign ram_rdata = ram_re ? ram[ram_addr[7:2]] : 32'h0;
  always @(posedge clk) begin
    if (preload) begin
      for (int i = 0; i < 64; i++) ram[i] <= init_word(i);
    end else if (ram_we) begin
      ram[ram_addr[7:2]] <= ram_wdata;
    end
  end

  typedef struct {
    bit          stall;
    logic [31:0] crd;
    bit          ack;
    bit          we;
    bit          re;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          cnt;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] dbg_q[$];
  int          n_chk = 0;
  int          n_pass = 0;

  // Reference model: memory image, debug-ack flag, how long the debug side has waited.
  logic [31:0] m_mem [0:63];
  bit          m_dack;
  int          m_wait;
  int          m_stall;
  logic [31:0] m_dbg_rdata;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
    n_chk++;
    if (act === expv) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
  endtask

  task automatic model_reset();
    m_dack = 0;
    m_wait = 0;
    m_stall = 0;
    m_dbg_rdata = '0;
  endtask

  task automatic model_step();
    exp_t e;
    bit   elig, dg, cg;
    elig = dbg_req && !m_dack;
    dg   = elig && (!cpu_req || m_wait >= MAXRUN);
    cg   = cpu_req && !dg;
    e.ack = m_dack;
    e.stall = cpu_req && !cg;
    e.cnt = m_stall;
    e.we = 0; e.re = 0; e.addr = '0; e.wdata = '0; e.crd = '0;
    if (cg) begin
      e.we = cpu_we; e.re = !cpu_we; e.addr = cpu_addr; e.wdata = cpu_wdata;
      if (!cpu_we) e.crd = m_mem[cpu_addr[7:2]];
      else m_mem[cpu_addr[7:2]] = cpu_wdata;
    end else if (dg) begin
      e.we = dbg_we; e.re = !dbg_we; e.addr = dbg_addr; e.wdata = dbg_wdata;
      if (!dbg_we) m_dbg_rdata = m_mem[dbg_addr[7:2]];
      else m_mem[dbg_addr[7:2]] = dbg_wdata;
      dbg_q.push_back(m_dbg_rdata);
    end
    exp_q.push_back(e);
    if (e.stall) m_stall++;
    m_dack = dg;
    if (dg || !dbg_req) m_wait = 0;
    else if (cg && elig && m_wait < MAXRUN) m_wait++;
  endtask

  task automatic cyc(input logic cr, input logic cw, input logic [31:0] ca, input logic [31:0] cd,
                     input logic dr, input logic dw, input logic [31:0] da, input logic [31:0] dd);
    @(posedge clk);
    #1;
    cpu_req = cr; cpu_we = cw; cpu_addr = ca; cpu_wdata = cd;
    dbg_req = dr; dbg_we = dw; dbg_addr = da; dbg_wdata = dd;
    model_step();
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (mon_en && exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("cpu_stall", 64'(cpu_stall), 64'(e.stall));
      chk("cpu_rdata", 64'(cpu_rdata), 64'(e.crd));
      chk("dbg_ack", 64'(dbg_ack), 64'(e.ack));
      chk("ram_we", 64'(ram_we), 64'(e.we));
      chk("ram_re", 64'(ram_re), 64'(e.re));
      chk("ram_addr", 64'(ram_addr), 64'(e.addr));
      chk("ram_wdata", 64'(ram_wdata), 64'(e.wdata));
      chk("stall_cnt", 64'(stall_cnt), 64'((e.cnt > 65535) ? 65535 : e.cnt));
      chk("stall_cnt_w4", 64'(sm_stall_cnt), 64'((e.cnt > 15) ? 15 : e.cnt));
      if (dbg_ack) begin
        if (dbg_q.size() == 0) chk("dbg_ack_unexpected", 64'(1), 64'(0));
        else chk("dbg_rdata", 64'(dbg_rdata), 64'(dbg_q.pop_front()));
      end
    end
  end

  logic        r_dreq, r_dwe;
  logic [31:0] r_daddr, r_dwdata;

  initial begin
    for (int i = 0; i < 64; i++) m_mem[i] = init_word(i);
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    preload = 1'b0;
    chk("rst_dbg_ack", 64'(dbg_ack), 64'(0));
    chk("rst_dbg_rdata", 64'(dbg_rdata), 64'(0));
    chk("rst_stall_cnt", 64'(stall_cnt), 64'(0));
    chk("rst_ram_we", 64'(ram_we), 64'(0));
    chk("rst_ram_re", 64'(ram_re), 64'(0));
    reset = 1'b0;
    mon_en = 1'b1;

    // CPU load, debug write, CPU read-back of the debug write
    cyc(1, 0, 32'h10, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 1, 1, 32'h20, 32'h12345678);
    cyc(0, 0, 0, 0, 0, 0, 0, 0);
    cyc(1, 0, 32'h20, 0, 0, 0, 0, 0);

    // Starvation: debug read waits behind MAXRUN CPU grants, dropped in its ack cycle
    for (int i = 0; i < 10; i++)
      cyc(1, 0, 32'($urandom_range(0, 63)) << 2, 0, (i <= MAXRUN) ? 1'b1 : 1'b0, 0, 32'h20, 0);
    chk("starve_stall_cnt", 64'(stall_cnt), 64'(1));

    // Debug alone, request held high: one access every two cycles
    for (int i = 0; i < 6; i++) cyc(0, 0, 0, 0, 1, 0, 32'h10, 0);
    cyc(0, 0, 0, 0, 0, 0, 0, 0);

    // Reset during the ack cycle of a debug read
    cyc(0, 0, 0, 0, 1, 0, 32'h10, 0);
    @(posedge clk);
    #1;
    dbg_req = 1'b0;
    mon_en = 1'b0;
    chk("dack_before_reset", 64'(dbg_ack), 64'(1));
    exp_q.delete();
    dbg_q.delete();
    #1 reset = 1'b1;
    #1;
    chk("async_rst_dbg_ack", 64'(dbg_ack), 64'(0));
    chk("async_rst_dbg_rdata", 64'(dbg_rdata), 64'(0));
    @(posedge clk);
    #1;
    reset = 1'b0;
    model_reset();
    mon_en = 1'b1;
    cyc(0, 0, 0, 0, 0, 0, 0, 0);

    // Random traffic with a well-behaved debug master
    r_dreq = 0; r_dwe = 0; r_daddr = '0; r_dwdata = '0;
    for (int i = 0; i < 400; i++) begin
      if (m_dack || !r_dreq) begin
        r_dreq   = ($urandom_range(0, 2) == 0);
        r_dwe    = $urandom_range(0, 1) == 1;
        r_daddr  = 32'($urandom_range(0, 15)) << 2;
        r_dwdata = $urandom;
      end
      cyc($urandom_range(0, 2) != 0, $urandom_range(0, 1) == 1,
          32'($urandom_range(0, 15)) << 2, $urandom, r_dreq, r_dwe, r_daddr, r_dwdata);
    end

    // Continuous contention drives the narrow counter into saturation
    for (int i = 0; i < 140; i++)
      cyc(1, 0, 32'($urandom_range(0, 63)) << 2, 0, 1, 0, 32'($urandom_range(0, 63)) << 2, 0);
    cyc(0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    @(negedge clk);
    chk("stall_cnt_w4_saturated", 64'(sm_stall_cnt), 64'(15));
    chk("dbg_q_drained", 64'(dbg_q.size()), 64'(0));
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
